// File: rtl/divider_arb_pkg.sv
// Shared types and the round-robin picker for the divider rate arbiter.
package divider_arb_pkg;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} arb_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int MAX_REQ   = 8;

  // One-hot of the first set request at or after ptr, wrapping within n requesters.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0] ptr,
                                                 input int n);
    logic [3:0] idx;
    rr_pick = '0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      idx = 4'(ptr) + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (k < n && req[idx[2:0]]) begin
        rr_pick = '0;
        rr_pick[idx[2:0]] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/divider_core.sv
// Half-period counter: toggles the divided clock and pulses tick at each boundary.
module divider_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_signal_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             reload,
  input  logic [WIDTH-1:0] active_limit,
  output logic             boundary,
  output logic             tick,
  output logic             clk_signal_out
);

  logic [WIDTH-1:0] r_cnt;

  // Counter starts at 1, so a limit of 0 still fires every cycle.
  assign boundary = enable && (r_cnt >= active_limit);

  always_ff @(posedge clk_signal_in) begin
    if (reset) begin
      r_cnt          <= WIDTH'(1);
      tick           <= 1'b0;
      clk_signal_out <= 1'b0;
    end else if (reload) begin
      r_cnt <= WIDTH'(1);
      tick  <= 1'b0;
    end else if (boundary) begin
      r_cnt          <= WIDTH'(1);
      tick           <= 1'b1;
      clk_signal_out <= ~clk_signal_out;
    end else begin
      if (enable) r_cnt <= r_cnt + WIDTH'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/divider_rate_arbiter.sv
// Round-robin arbitrated clock divider; limits change only at half-period boundaries.
// Define DIVIDER_ARB_IMMEDIATE_EN to let requester 0 override and apply at once.
module divider_rate_arbiter
  import divider_arb_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          WIDTH         = DEF_WIDTH,
  parameter int unsigned DEFAULT_LIMIT = 1136
) (
  input  logic                     clk_signal_in,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_limit,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         active_limit,
  output logic                     tick,
  output logic                     clk_signal_out
);

`ifdef DIVIDER_ARB_IMMEDIATE_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  arb_state_t         r_state, w_state_n;
  logic [2:0]         r_ptr, w_ptr_n;
  logic [WIDTH-1:0]   r_pend, w_pend_n, r_act, w_act_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n;
  logic               r_busy, w_busy_n, r_imm, w_imm_n;
  logic               w_reload, w_boundary;
  logic [MAX_REQ-1:0] w_pick;
  logic [2:0]         w_idx;

  always_comb begin
    w_pick = rr_pick(MAX_REQ'(req), r_ptr, NUM_REQ);
    if (IMM_EN && req[0]) w_pick = MAX_REQ'(1);
    w_idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (w_pick[i]) w_idx = 3'(i);
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_pend_n  = r_pend;
    w_act_n   = r_act;
    w_grant_n = '0;
    w_busy_n  = r_busy;
    w_imm_n   = r_imm;
    w_reload  = 1'b0;
    case (r_state)
      IDLE: if (|req) begin
        w_grant_n = w_pick[NUM_REQ-1:0];
        w_pend_n  = req_limit[w_idx*WIDTH +: WIDTH];
        w_ptr_n   = (int'(w_idx) == NUM_REQ-1) ? 3'd0 : w_idx + 3'd1;
        w_busy_n  = 1'b1;
        w_imm_n   = IMM_EN && (w_idx == 3'd0);
        w_state_n = PENDING;
      end
      PENDING: begin
        // A boundary in the grant cycle must not consume the value just latched.
        if (r_imm || !enable || (w_boundary && r_grant == '0)) begin
          w_act_n   = r_pend;
          w_busy_n  = 1'b0;
          w_imm_n   = 1'b0;
          w_reload  = r_imm;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_signal_in) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_pend  <= '0;
      r_act   <= WIDTH'(DEFAULT_LIMIT);
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_imm   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_pend  <= w_pend_n;
      r_act   <= w_act_n;
      r_grant <= w_grant_n;
      r_busy  <= w_busy_n;
      r_imm   <= w_imm_n;
    end
  end

  divider_core #(.WIDTH(WIDTH)) u_core (
    .clk_signal_in  (clk_signal_in),
    .reset          (reset),
    .enable         (enable),
    .reload         (w_reload),
    .active_limit   (r_act),
    .boundary       (w_boundary),
    .tick           (tick),
    .clk_signal_out (clk_signal_out)
  );

  assign grant        = r_grant;
  assign busy         = r_busy;
  assign active_limit = r_act;

endmodule

// File: tb/tb_divider_rate_arbiter.sv
// Bench for divider_rate_arbiter: directed table, corner sequences, random vs reference model.
module tb_divider_rate_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int DL = 4;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   lim;
  logic [N-1:0]     grant;
  logic             busy, tick, clk_out;
  logic [W-1:0]     act;

  divider_rate_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEFAULT_LIMIT(DL)) dut (
    .clk_signal_in(clk), .reset(rst), .enable(en), .req(req), .req_limit(lim),
    .grant(grant), .busy(busy), .active_limit(act), .tick(tick), .clk_signal_out(clk_out)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;

  // Reference model: phase position within the half-period plus a pending slot.
  logic         m_out = 0, m_tick = 0, m_busy = 0, m_fresh = 0, m_imm = 0;
  logic [N-1:0] m_grant = '0;
  logic [W-1:0] m_act = DL, m_pend = '0;
  int           m_ptr = 0, m_ph = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic model_step();
    int half, w, nph;
    bit bnd, nout, ntick, nbusy, nimm;
    logic [N-1:0] ng;
    logic [W-1:0] nact;
    if (rst) begin
      m_out = 0; m_tick = 0; m_busy = 0; m_fresh = 0; m_imm = 0;
      m_grant = '0; m_act = DL; m_ptr = 0; m_ph = 0;
      return;
    end
    half  = (m_act == 0) ? 1 : int'(m_act);
    bnd   = en && (m_ph + 1 >= half);
    ntick = bnd;
    nout  = m_out ^ bnd;
    nph   = !en ? m_ph : (bnd ? 0 : m_ph + 1);
    nact  = m_act; nbusy = m_busy; nimm = m_imm; ng = '0;
    if (!m_busy) begin
      if (req != 0) begin
        w = -1;
`ifdef DIVIDER_ARB_IMMEDIATE_EN
        if (req[0]) begin w = 0; nimm = 1; end
`endif
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        ng[w]  = 1'b1;
        m_pend = lim[w*W +: W];
        m_ptr  = (w + 1) % N;
        nbusy  = 1;
      end
    end else if (m_imm) begin
      nact = m_pend; nbusy = 0; nimm = 0; nph = 0; nout = m_out; ntick = 0;
    end else if (!en || (bnd && !m_fresh)) begin
      nact = m_pend; nbusy = 0;
    end
    m_fresh = (ng != 0);
    m_grant = ng; m_out = nout; m_tick = ntick; m_ph = nph;
    m_act = nact; m_busy = nbusy; m_imm = nimm;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("clk_out", clk_out, m_out);
    chk("tick", tick, m_tick);
    chk("busy", busy, m_busy);
    chk("grant", grant, m_grant);
    chk("active_limit", act, m_act);
  endtask

  typedef struct {
    bit rst, en; logic [N-1:0] req; logic [W-1:0] l1;
    bit eo, et, eb; logic [N-1:0] eg; logic [W-1:0] el;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int n;
    int got[$];
    int exp_rr[4];
    tbl = '{
      '{1,1,4'b0000,0, 0,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 0,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 0,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 0,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 1,1,0,4'b0000,4},
      '{0,1,4'b0000,0, 1,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 1,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 1,0,0,4'b0000,4},
      '{0,1,4'b0000,0, 0,1,0,4'b0000,4},
      '{0,1,4'b0010,2, 0,0,1,4'b0010,4},
      '{0,1,4'b0000,2, 0,0,1,4'b0000,4},
      '{0,1,4'b0000,2, 0,0,1,4'b0000,4},
      '{0,1,4'b0000,2, 1,1,0,4'b0000,2},
      '{0,1,4'b0000,2, 1,0,0,4'b0000,2},
      '{0,1,4'b0000,2, 0,1,0,4'b0000,2}
    };
    rst = 1; en = 1; req = '0; lim = '0;

    // Directed table: default limit then one rate change from requester 1.
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; req = tbl[i].req; lim[W +: W] = tbl[i].l1;
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("tbl%0d_out", i), clk_out, tbl[i].eo);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].et);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("tbl%0d_limit", i), act, tbl[i].el);
    end

`ifndef DIVIDER_ARB_IMMEDIATE_EN
    // Two requesters held continuously must alternate.
    rst = 1; req = '0; cycle(); rst = 0;
    req = 4'b0101; lim[0 +: W] = 3; lim[2*W +: W] = 5;
    exp_rr = '{0, 2, 0, 2};
    n = 0;
    while (got.size() < 4 && n < 200) begin
      cycle(); n++;
      for (int i = 0; i < N; i++) if (grant[i]) got.push_back(i);
    end
    if (got.size() < 4) chk("rr_timeout", got.size(), 4);
    else for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), got[k], exp_rr[k]);
    req = '0;
`endif

    // Limit 0 toggles every cycle.
    rst = 1; cycle(); rst = 0;
    req = 4'b1000; lim[3*W +: W] = 0; cycle(); req = '0;
    repeat (10) cycle();
    for (int k = 0; k < 4; k++) begin cycle(); chk("lim0_tick", tick, 1); end

    // enable=0 while pending applies at once; output frozen.
    rst = 1; cycle(); rst = 0;
    req = 4'b0010; lim[W +: W] = 7; cycle();
    chk("en0_grant", grant, 4'b0010);
    req = '0; en = 0; cycle();
    chk("en0_limit", act, 7); chk("en0_out", clk_out, 0); chk("en0_tick", tick, 0);
    cycle(); chk("en0_busy", busy, 0);
    en = 1; n = 0;
    while (!tick && n < 30) begin cycle(); n++; end
    n = 0;
    do begin cycle(); n++; end while (!tick && n < 30);
    chk("en0_half", n, 7);

    // Reset while pending aborts.
    rst = 1; cycle(); rst = 0;
    req = 4'b0100; lim[2*W +: W] = 5; cycle(); req = '0; cycle();
    rst = 1; cycle();
    chk("rstp_busy", busy, 0); chk("rstp_grant", grant, 0);
    chk("rstp_limit", act, DL); chk("rstp_out", clk_out, 0);
    rst = 0;

`ifdef DIVIDER_ARB_IMMEDIATE_EN
    // Requester 0 override reloads without a toggle.
    cycle();
    req = 4'b0001; lim[0 +: W] = 9; cycle();
    chk("imm_grant", grant, 4'b0001);
    req = '0; cycle();
    chk("imm_limit", act, 9); chk("imm_tick", tick, 0);
    n = 0;
    do begin cycle(); n++; end while (!tick && n < 30);
    chk("imm_half", n, 9);
`endif

    // Randomized traffic against the model.
    rst = 1; cycle(); rst = 0; req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_grant[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          lim[i*W +: W] = W'($urandom_range(0, 6));
        end
      end
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
